// File: rtl/ex_mem_stage_if.sv
// Execute-stage bus: ID/EX register contents and forwarding sources flow in,
// EX/MEM register contents and the front-end stall flow out.
interface ex_mem_stage_if #(
   parameter int DATA_W = 32
);
   // ID/EX register contents
   logic [1:0]        wb_in;
   logic [2:0]        m_in;
   logic [3:0]        ex_in;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic [DATA_W-1:0] imm_value;
   logic [4:0]        reg_rs;
   logic [4:0]        reg_rt;
   logic [4:0]        reg_rd;
   // forwarding sources from the later stages
   logic              mem_reg_write;
   logic [4:0]        mem_rd;
   logic [DATA_W-1:0] mem_alu_result;
   logic              wb_reg_write;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   // stage outputs
   logic              stall;
   logic [1:0]        wb_out;
   logic [2:0]        m_out;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] store_data;
   logic [4:0]        dest_reg;
   logic              zero;

   // the execute stage itself
   modport slave (
      input  wb_in, m_in, ex_in, data_a, data_b, imm_value, reg_rs, reg_rt, reg_rd,
      input  mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
      output stall, wb_out, m_out, alu_result, store_data, dest_reg, zero
   );

   // the surrounding pipeline (decode, memory and writeback stages)
   modport master (
      output wb_in, m_in, ex_in, data_a, data_b, imm_value, reg_rs, reg_rt, reg_rd,
      output mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
      input  stall, wb_out, m_out, alu_result, store_data, dest_reg, zero
   );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with the EX/MEM pipeline register.
// Operand forwarding from MEM (priority) and WB, single-cycle ALU ops, and a
// DATA_W-step shift-add multiplier that stalls the front end while it runs.
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int FWD_EN = 1
) (
   input  logic          clock,
   input  logic          reset,
   ex_mem_stage_if.slave bus
);

   localparam int              CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   localparam logic [5:0] FN_MUL = 6'h18;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // decoded control
   logic              reg_dst_s;
   logic [1:0]        alu_op_s;
   logic              alu_src_s;
   logic [5:0]        funct_s;
   logic              mul_req_s;

   // datapath
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic [DATA_W-1:0] op_b_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              stall_s;
   logic              capture_s;
   logic [DATA_W-1:0] cap_val_s;
   logic              stall_out_s;

   // multiplier state
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mul_a_q, mul_a_d;
   logic [DATA_W-1:0] mul_b_q, mul_b_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   // EX/MEM register
   logic [1:0]        wb_out_q, wb_out_d;
   logic [2:0]        m_out_q, m_out_d;
   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [DATA_W-1:0] store_data_q, store_data_d;
   logic [4:0]        dest_reg_q, dest_reg_d;
   logic              zero_q, zero_d;

   assign reg_dst_s = bus.ex_in[3];
   assign alu_op_s  = bus.ex_in[2:1];
   assign alu_src_s = bus.ex_in[0];
   assign funct_s   = bus.imm_value[5:0];
   assign mul_req_s = (alu_op_s == 2'b10) && (funct_s == FN_MUL);

   // Forwarding muxes: a pending write in MEM is newer than one in WB; r0 never forwards.
   always_comb begin
      fwd_a_s = bus.data_a;
      fwd_b_s = bus.data_b;
      if ((FWD_EN != 0) && bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.reg_rs)) begin
         fwd_a_s = bus.mem_alu_result;
      end else if ((FWD_EN != 0) && bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.reg_rs)) begin
         fwd_a_s = bus.wb_data;
      end else begin
         fwd_a_s = bus.data_a;
      end
      if ((FWD_EN != 0) && bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.reg_rt)) begin
         fwd_b_s = bus.mem_alu_result;
      end else if ((FWD_EN != 0) && bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.reg_rt)) begin
         fwd_b_s = bus.wb_data;
      end else begin
         fwd_b_s = bus.data_b;
      end
   end

   // Single-cycle ALU; MUL yields 0 here because its result comes from the FSM accumulator.
   always_comb begin
      op_b_s    = alu_src_s ? bus.imm_value : fwd_b_s;
      alu_res_s = {DATA_W{1'b0}};
      case (alu_op_s)
         2'b00: alu_res_s = fwd_a_s + op_b_s;
         2'b01: alu_res_s = fwd_a_s - op_b_s;
         2'b11: alu_res_s = fwd_a_s | op_b_s;
         2'b10: begin
            case (funct_s)
               FN_ADD:  alu_res_s = fwd_a_s + op_b_s;
               FN_SUB:  alu_res_s = fwd_a_s - op_b_s;
               FN_AND:  alu_res_s = fwd_a_s & op_b_s;
               FN_OR:   alu_res_s = fwd_a_s | op_b_s;
               FN_NOR:  alu_res_s = ~(fwd_a_s | op_b_s);
               FN_SLT:  alu_res_s = ($signed(fwd_a_s) < $signed(op_b_s)) ? DATA_W'(1'b1) : {DATA_W{1'b0}};
               default: alu_res_s = {DATA_W{1'b0}};
            endcase
         end
         default: alu_res_s = {DATA_W{1'b0}};
      endcase
   end

   // Multiplier FSM: latch operands, DATA_W add-shift steps, then hand the product to EX/MEM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      acc_d     = acc_q;
      stall_s   = 1'b0;
      capture_s = 1'b0;
      cap_val_s = alu_res_s;
      case (state_q)
         S_IDLE: begin
            if (mul_req_s) begin
               stall_s = 1'b1;
               mul_a_d = fwd_a_s;
               mul_b_d = fwd_b_s;
               acc_d   = {DATA_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_BUSY;
            end else begin
               capture_s = 1'b1;
               cap_val_s = alu_res_s;
            end
         end
         S_BUSY: begin
            stall_s = 1'b1;
            if (mul_a_q[0]) begin
               acc_d = acc_q + mul_b_q;
            end else begin
               acc_d = acc_q;
            end
            mul_a_d = mul_a_q >> 1;
            mul_b_d = mul_b_q << 1;
            if (cnt_q == LAST_STEP) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            capture_s = 1'b1;
            cap_val_s = acc_q;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // EX/MEM next value: capture a result or insert a bubble that keeps the data fields.
   always_comb begin
      wb_out_d     = 2'b00;
      m_out_d      = 3'b000;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      dest_reg_d   = dest_reg_q;
      zero_d       = zero_q;
      if (capture_s) begin
         wb_out_d     = bus.wb_in;
         m_out_d      = bus.m_in;
         alu_result_d = cap_val_s;
         store_data_d = fwd_b_s;
         dest_reg_d   = reg_dst_s ? bus.reg_rd : bus.reg_rt;
         zero_d       = (cap_val_s == {DATA_W{1'b0}});
      end else begin
         wb_out_d = 2'b00;
         m_out_d  = 3'b000;
      end
   end

   // Stall is suppressed while reset is held so the front end is never frozen by stale state.
   always_comb begin
      stall_out_s = 1'b0;
      if (reset) begin
         stall_out_s = 1'b0;
      end else begin
         stall_out_s = stall_s;
      end
   end

   // State and pipeline registers; reset aborts any multiply in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         mul_a_q      <= {DATA_W{1'b0}};
         mul_b_q      <= {DATA_W{1'b0}};
         acc_q        <= {DATA_W{1'b0}};
         wb_out_q     <= 2'b00;
         m_out_q      <= 3'b000;
         alu_result_q <= {DATA_W{1'b0}};
         store_data_q <= {DATA_W{1'b0}};
         dest_reg_q   <= 5'd0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         acc_q        <= acc_d;
         wb_out_q     <= wb_out_d;
         m_out_q      <= m_out_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         dest_reg_q   <= dest_reg_d;
         zero_q       <= zero_d;
      end
   end

   assign bus.stall      = stall_out_s;
   assign bus.wb_out     = wb_out_q;
   assign bus.m_out      = m_out_q;
   assign bus.alu_result = alu_result_q;
   assign bus.store_data = store_data_q;
   assign bus.dest_reg   = dest_reg_q;
   assign bus.zero       = zero_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of single-cycle vectors plus
// hand-written multiply, back-to-back multiply and reset-during-multiply sequences.
module tb_ex_mem_stage;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   ex_mem_stage_if #(.DATA_W(32)) bus ();

   ex_mem_stage #(.DATA_W(32), .FWD_EN(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        mrw;
      logic [4:0]  mrd;
      logic [31:0] mres;
      logic        wrw;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic [31:0] e_res;
      logic [31:0] e_store;
      logic [4:0]  e_dest;
      logic        e_zero;
   } vec_t;

   localparam int NV = 16;
   vec_t  vecs [NV];
   string names [NV];

   function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                               input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat,
                               input logic [31:0] e_res, input logic [31:0] e_store,
                               input logic [4:0] e_dest, input logic e_zero);
      vec_t v;
      v.wb = wb; v.m = m; v.ex = ex; v.a = a; v.b = b; v.imm = imm;
      v.rs = rs; v.rt = rt; v.rd = rd;
      v.mrw = mrw; v.mrd = mrd; v.mres = mres;
      v.wrw = wrw; v.wrd = wrd; v.wdat = wdat;
      v.e_res = e_res; v.e_store = e_store; v.e_dest = e_dest; v.e_zero = e_zero;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.wb_in          = v.wb;
      bus.m_in           = v.m;
      bus.ex_in          = v.ex;
      bus.data_a         = v.a;
      bus.data_b         = v.b;
      bus.imm_value      = v.imm;
      bus.reg_rs         = v.rs;
      bus.reg_rt         = v.rt;
      bus.reg_rd         = v.rd;
      bus.mem_reg_write  = v.mrw;
      bus.mem_rd         = v.mrd;
      bus.mem_alu_result = v.mres;
      bus.wb_reg_write   = v.wrw;
      bus.wb_rd          = v.wrd;
      bus.wb_data        = v.wdat;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wb_out"},     32'(bus.wb_out),   32'd0);
      chk({tag, "_m_out"},      32'(bus.m_out),    32'd0);
      chk({tag, "_alu_result"}, bus.alu_result,    32'd0);
      chk({tag, "_store_data"}, bus.store_data,    32'd0);
      chk({tag, "_dest_reg"},   32'(bus.dest_reg), 32'd0);
      chk({tag, "_zero"},       32'(bus.zero),     32'd0);
      chk({tag, "_stall"},      32'(bus.stall),    32'd0);
   endtask

   // Apply one table vector for one cycle and compare the registered results.
   task automatic run_vec(input int i);
      drive(vecs[i]);
      @(posedge clock); #1;
      chk({names[i], "_alu_result"}, bus.alu_result,    vecs[i].e_res);
      chk({names[i], "_store_data"}, bus.store_data,    vecs[i].e_store);
      chk({names[i], "_dest_reg"},   32'(bus.dest_reg), 32'(vecs[i].e_dest));
      chk({names[i], "_zero"},       32'(bus.zero),     32'(vecs[i].e_zero));
      chk({names[i], "_wb_out"},     32'(bus.wb_out),   32'(vecs[i].wb));
      chk({names[i], "_m_out"},      32'(bus.m_out),    32'(vecs[i].m));
      chk({names[i], "_stall"},      32'(bus.stall),    32'd0);
   endtask

   // One full multiply: stall length, bubbles, held data, then the product in EX/MEM.
   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [31:0] prev_res);
      int n;
      bit bub_ok;
      bit hold_ok;
      drive(mk(2'b10, 3'b000, 4'b1100, a, b, 32'h18, 5'd2, 5'd10, 5'd8,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0));
      #1;
      n = 0; bub_ok = 1'b1; hold_ok = 1'b1;
      while (bus.stall === 1'b1 && n < 40) begin
         n++;
         if (n == 3) begin
            // a forwarding hit on rs that appears mid-multiply must not disturb the latched operand
            bus.mem_reg_write  = 1'b1;
            bus.mem_rd         = 5'd2;
            bus.mem_alu_result = 32'd0;
         end
         @(posedge clock); #1;
         if (bus.wb_out !== 2'b00 || bus.m_out !== 3'b000) bub_ok = 1'b0;
         if (bus.alu_result !== prev_res) hold_ok = 1'b0;
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
      chk({tag, "_bubbles"}, 32'(bub_ok), 32'd1);
      chk({tag, "_bubble_hold"}, 32'(hold_ok), 32'd1);
      @(posedge clock); #1;
      chk({tag, "_product"}, bus.alu_result, exp);
      chk({tag, "_wb_out"}, 32'(bus.wb_out), 32'h2);
      chk({tag, "_dest_reg"}, 32'(bus.dest_reg), 32'd8);
      chk({tag, "_zero"}, 32'(bus.zero), (exp == 32'd0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;

      //            wb     m       ex       a              b              imm            rs    rt    rd    mrw   mrd   mres          wrw   wrd   wdat        e_res          e_store        e_dest e_zero
      vecs[0]  = mk(2'b10, 3'b000, 4'b1100, 32'd5,         32'd7,         32'h20,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd12,        32'd7,         5'd3, 1'b0);
      vecs[1]  = mk(2'b10, 3'b000, 4'b1100, 32'd55,        32'd100,       32'h22,        5'd4, 5'd5, 5'd6, 1'b1, 5'd4, 32'd100,      1'b1, 5'd4, 32'd200,    32'd0,         32'd100,       5'd6, 1'b1);
      vecs[2]  = mk(2'b10, 3'b000, 4'b1100, 32'd9,         32'd1,         32'h20,        5'd0, 5'd2, 5'd3, 1'b1, 5'd0, 32'd999,      1'b0, 5'd0, 32'd0,      32'd10,        32'd1,         5'd3, 1'b0);
      vecs[3]  = mk(2'b10, 3'b000, 4'b1100, 32'd9,         32'd2,         32'h20,        5'd7, 5'd2, 5'd3, 1'b0, 5'd7, 32'd999,      1'b1, 5'd7, 32'd50,     32'd52,        32'd2,         5'd3, 1'b0);
      vecs[4]  = mk(2'b10, 3'b000, 4'b1100, 32'd1,         32'd5,         32'h20,        5'd1, 5'd9, 5'd3, 1'b1, 5'd9, 32'h1234,     1'b0, 5'd0, 32'd0,      32'h1235,      32'h1234,      5'd3, 1'b0);
      vecs[5]  = mk(2'b11, 3'b010, 4'b0001, 32'd100,       32'd77,        32'hFFFF_FFFC, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd96,        32'd77,        5'd2, 1'b0);
      vecs[6]  = mk(2'b00, 3'b100, 4'b0010, 32'd8,         32'd8,         32'h0,         5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd0,         32'd8,         5'd2, 1'b1);
      vecs[7]  = mk(2'b10, 3'b000, 4'b0111, 32'hF0,        32'd1,         32'h0F,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'hFF,        32'd1,         5'd2, 1'b0);
      vecs[8]  = mk(2'b10, 3'b000, 4'b1100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h24,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'h0F00_0F00, 32'h0F0F_0F0F, 5'd3, 1'b0);
      vecs[9]  = mk(2'b10, 3'b000, 4'b1100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h25,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'hFF0F_FF0F, 32'h0F0F_0F0F, 5'd3, 1'b0);
      vecs[10] = mk(2'b10, 3'b000, 4'b1100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h27,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'h00F0_00F0, 32'h0F0F_0F0F, 5'd3, 1'b0);
      vecs[11] = mk(2'b10, 3'b000, 4'b1100, 32'hFFFF_FFFF, 32'd1,         32'h2A,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd1,         32'd1,         5'd3, 1'b0);
      vecs[12] = mk(2'b10, 3'b000, 4'b1100, 32'd5,         32'd3,         32'h2A,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd0,         32'd3,         5'd3, 1'b1);
      vecs[13] = mk(2'b10, 3'b000, 4'b1100, 32'd5,         32'd3,         32'h3F,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd0,         32'd3,         5'd3, 1'b1);
      vecs[14] = mk(2'b10, 3'b000, 4'b1100, 32'hFFFF_FFFF, 32'd2,         32'h20,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'd1,         32'd2,         5'd3, 1'b0);
      vecs[15] = mk(2'b10, 3'b000, 4'b1100, 32'd0,         32'd1,         32'h22,        5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      32'hFFFF_FFFF, 32'd1,         5'd3, 1'b0);
      names[0] = "add";        names[1] = "fwd_mem_wins"; names[2] = "rd0_no_fwd";  names[3] = "fwd_wb";
      names[4] = "fwd_b_mem";  names[5] = "lw_addi";      names[6] = "beq_sub";     names[7] = "ori";
      names[8] = "and";        names[9] = "or";           names[10] = "nor";        names[11] = "slt_neg";
      names[12] = "slt_false"; names[13] = "bad_funct";   names[14] = "add_wrap";   names[15] = "sub_wrap";

      // reset held for two cycles with arbitrary inputs (possibly a MUL request)
      reset              = 1'b1;
      bus.wb_in          = 2'($urandom);
      bus.m_in           = 3'($urandom);
      bus.ex_in          = 4'b1100;
      bus.data_a         = $urandom;
      bus.data_b         = $urandom;
      bus.imm_value      = 32'h18;
      bus.reg_rs         = 5'($urandom);
      bus.reg_rt         = 5'($urandom);
      bus.reg_rd         = 5'($urandom);
      bus.mem_reg_write  = 1'($urandom);
      bus.mem_rd         = 5'($urandom);
      bus.mem_alu_result = $urandom;
      bus.wb_reg_write   = 1'($urandom);
      bus.wb_rd          = 5'($urandom);
      bus.wb_data        = $urandom;
      @(posedge clock); #1;
      chk_all_zero("reset_c1");
      @(posedge clock); #1;
      chk_all_zero("reset_c2");
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_vec(i);
      end

      // multiply after a load so the bubbles visibly clear wb/m and hold 96
      run_vec(5);
      do_mul("mul_ffff_x3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'd96);
      // back-to-back multiplies, no gap cycle
      do_mul("mul_zero", 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD);
      do_mul("mul_wrap", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32'd0);

      // reset in BUSY cycle 10 aborts the multiply
      run_vec(5);
      drive(mk(2'b10, 3'b000, 4'b1100, 32'd7, 32'd6, 32'h18, 5'd2, 5'd10, 5'd8,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0));
      #1;
      chk("mid_mul_stall_start", 32'(bus.stall), 32'd1);
      for (int k = 0; k < 11; k++) begin
         @(posedge clock); #1;
      end
      chk("mid_mul_busy_stall", 32'(bus.stall), 32'd1);
      chk("mid_mul_busy_hold", bus.alu_result, 32'd96);
      reset = 1'b1;
      #1;
      chk("mid_mul_reset_stall", 32'(bus.stall), 32'd0);
      @(posedge clock); #1;
      chk_all_zero("mid_mul_reset");
      reset = 1'b0;
      drive(vecs[0]);
      #1;
      chk("post_reset_add_stall", 32'(bus.stall), 32'd0);
      @(posedge clock); #1;
      chk("post_reset_add_result", bus.alu_result, 32'd12);
      chk("post_reset_add_wb_out", 32'(bus.wb_out), 32'h2);
      chk("post_reset_add_dest", 32'(bus.dest_reg), 32'd3);
      run_vec(11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
